// File: rtl/vector_writeback_arbiter_if.sv
// vector_writeback_arbiter_if: execute/load writeback requests and the register-file write port
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 512
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

interface vector_writeback_arbiter_if #(parameter int MEM_FIFO_DEPTH = 4);
  logic                               ex_valid;
  logic                               ex_ready;
  logic [`REG_IDX_WIDTH-1:0]          ex_reg;
  logic [`VECTOR_BITS-1:0]            ex_value;
  logic [`VECTOR_LANES-1:0]           ex_mask;
  logic                               mem_valid;
  logic                               mem_ready;
  logic [`REG_IDX_WIDTH-1:0]          mem_reg;
  logic [`VECTOR_BITS-1:0]            mem_value;
  logic [`VECTOR_LANES-1:0]           mem_mask;
  logic                               wb_enable_vector_writeback;
  logic [`REG_IDX_WIDTH-1:0]          wb_writeback_reg;
  logic [`VECTOR_BITS-1:0]            wb_writeback_value;
  logic [`VECTOR_LANES-1:0]           wb_writeback_mask;
  logic [$clog2(MEM_FIFO_DEPTH):0]    mem_pending;
  modport master (
    output ex_valid, ex_reg, ex_value, ex_mask, mem_valid, mem_reg, mem_value, mem_mask,
    input  ex_ready, mem_ready, wb_enable_vector_writeback, wb_writeback_reg,
           wb_writeback_value, wb_writeback_mask, mem_pending
  );
  modport slave (
    input  ex_valid, ex_reg, ex_value, ex_mask, mem_valid, mem_reg, mem_value, mem_mask,
    output ex_ready, mem_ready, wb_enable_vector_writeback, wb_writeback_reg,
           wb_writeback_value, wb_writeback_mask, mem_pending
  );
endinterface

// File: rtl/vector_writeback_arbiter.sv
// vector_writeback_arbiter: merges execute writebacks with a queued load stream onto one
// register-file write port, giving loads priority once they have starved long enough.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 512
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

module vector_writeback_arbiter #(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input logic                  clk,
  input logic                  reset,
  vector_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL       = (AW+1)'(MEM_FIFO_DEPTH);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
  typedef enum logic {EX_PRIO, MEM_PRIO} state_t;
  state_t                    r_state;
  logic [AW:0]               r_count;
  logic [AW-1:0]             r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]             r_starve;
  logic [`REG_IDX_WIDTH-1:0] r_q_reg   [MEM_FIFO_DEPTH];
  logic [`VECTOR_BITS-1:0]   r_q_value [MEM_FIFO_DEPTH];
  logic [`VECTOR_LANES-1:0]  r_q_mask  [MEM_FIFO_DEPTH];
  logic                      r_wb_en;
  logic [`REG_IDX_WIDTH-1:0] r_wb_reg;
  logic [`VECTOR_BITS-1:0]   r_wb_value;
  logic [`VECTOR_LANES-1:0]  r_wb_mask;
  logic w_nonempty, w_mem_ready, w_ex_ready, w_push, w_grant_mem, w_grant_ex;
  assign w_nonempty  = r_count != '0;
  assign w_mem_ready = r_count < FULL;
  assign w_ex_ready  = (r_state == EX_PRIO) || !w_nonempty;
  // Grant decisions use registered occupancy only, so a load never bypasses the queue.
  assign w_grant_mem = w_nonempty && ((r_state == MEM_PRIO) || !bus.ex_valid);
  assign w_grant_ex  = bus.ex_valid && w_ex_ready;
  assign w_push      = bus.mem_valid && w_mem_ready;
  assign bus.ex_ready                   = w_ex_ready;
  assign bus.mem_ready                  = w_mem_ready;
  assign bus.mem_pending                = r_count;
  assign bus.wb_enable_vector_writeback = r_wb_en;
  assign bus.wb_writeback_reg           = r_wb_reg;
  assign bus.wb_writeback_value         = r_wb_value;
  assign bus.wb_writeback_mask          = r_wb_mask;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_reg[r_wr_ptr]   <= bus.mem_reg;
      r_q_value[r_wr_ptr] <= bus.mem_value;
      r_q_mask[r_wr_ptr]  <= bus.mem_mask;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= EX_PRIO;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_starve   <= '0;
      r_wb_en    <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_value <= '0;
      r_wb_mask  <= '0;
    end else begin
      r_count  <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_grant_mem};
      r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr <= w_grant_mem ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_starve <= (!w_nonempty || w_grant_mem) ? '0 :
                  (r_starve == STARVE_MAX) ? r_starve : r_starve + CW'(1);
      // MEM_PRIO always grants or finds the queue empty, so it lasts a single cycle.
      r_state  <= (r_state == EX_PRIO && r_starve == STARVE_MAX) ? MEM_PRIO : EX_PRIO;
      r_wb_en  <= w_grant_mem || w_grant_ex;
      if (w_grant_mem || w_grant_ex) begin
        r_wb_reg   <= w_grant_mem ? r_q_reg[r_rd_ptr]   : bus.ex_reg;
        r_wb_value <= w_grant_mem ? r_q_value[r_rd_ptr] : bus.ex_value;
        r_wb_mask  <= w_grant_mem ? r_q_mask[r_rd_ptr]  : bus.ex_mask;
      end
    end
  end
endmodule

// File: tb/tb_vector_writeback_arbiter.sv
// tb_vector_writeback_arbiter: directed and random stimulus against a queue-based model of the arbiter
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef VECTOR_BITS
`define VECTOR_BITS 512
`endif
`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

module tb_vector_writeback_arbiter;
  localparam int D = 4, LIM = 8;
  localparam int RW = `REG_IDX_WIDTH, VB = `VECTOR_BITS, VL = `VECTOR_LANES;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  vector_writeback_arbiter_if #(.MEM_FIFO_DEPTH(D)) bus();
  vector_writeback_arbiter #(.MEM_FIFO_DEPTH(D), .STARVE_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic [RW-1:0] rg; logic [VB-1:0] vl; logic [VL-1:0] mk;} wb_t;
  wb_t q[$];
  wb_t e_wb;
  bit  mp, e_en;
  int  starve;
  int  errors = 0, checks = 0;

  task automatic check(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VB-1:0] rand_vec();
    logic [VB-1:0] v;
    for (int i = 0; i < VB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    mp = 0;
    starve = 0;
    e_en = 0;
    e_wb = '{'0, '0, '0};
  endtask

  task automatic set_ex(input bit v, input logic [RW-1:0] r, input logic [VL-1:0] m);
    bus.ex_valid = v; bus.ex_reg = r; bus.ex_mask = m; bus.ex_value = rand_vec();
  endtask

  task automatic set_mem(input bit v, input logic [RW-1:0] r, input logic [VL-1:0] m);
    bus.mem_valid = v; bus.mem_reg = r; bus.mem_mask = m; bus.mem_value = rand_vec();
  endtask

  // One clock: check combinational readiness mid-cycle, advance the model at the edge,
  // then check the registered write port just after it.
  task automatic cycle();
    int pre;
    bit g_mem, g_ex, nmp;
    @(negedge clk);
    pre = q.size();
    check("mem_pending", bus.mem_pending, pre);
    check("mem_ready", bus.mem_ready, pre < D);
    check("ex_ready", bus.ex_ready, !mp || pre == 0);
    g_mem = pre > 0 && (mp || !bus.ex_valid);
    g_ex  = bus.ex_valid && (!mp || pre == 0);
    @(posedge clk);
    e_en = g_mem || g_ex;
    if (g_mem) e_wb = q.pop_front();
    else if (g_ex) e_wb = '{bus.ex_reg, bus.ex_value, bus.ex_mask};
    if (bus.mem_valid && pre < D) q.push_back('{bus.mem_reg, bus.mem_value, bus.mem_mask});
    nmp = !mp && starve == LIM;
    starve = (pre == 0 || g_mem) ? 0 : (starve < LIM ? starve + 1 : LIM);
    mp = nmp;
    #1;
    check("wb_enable", bus.wb_enable_vector_writeback, e_en);
    check("wb_reg", bus.wb_writeback_reg, e_wb.rg);
    check("wb_value", bus.wb_writeback_value, e_wb.vl);
    check("wb_mask", bus.wb_writeback_mask, e_wb.mk);
  endtask

  initial begin
    int lows;
    logic [RW-1:0] got[$];
    set_ex(0, '0, '0);
    set_mem(0, '0, '0);
    model_reset();
    #3;
    check("rst_wb_en", bus.wb_enable_vector_writeback, 0);
    check("rst_wb_reg", bus.wb_writeback_reg, 0);
    check("rst_wb_value", bus.wb_writeback_value, 0);
    check("rst_wb_mask", bus.wb_writeback_mask, 0);
    check("rst_pending", bus.mem_pending, 0);
    #9 reset = 1'b1;
    #1;
    check("post_rst_ex_ready", bus.ex_ready, 1);
    check("post_rst_mem_ready", bus.mem_ready, 1);
    // Execute-only writeback
    set_ex(1, 3, 16'hFFFF);
    cycle();
    set_ex(0, '0, '0);
    check("ex_only_en", bus.wb_enable_vector_writeback, 1);
    check("ex_only_reg", bus.wb_writeback_reg, 3);
    check("ex_only_mask", bus.wb_writeback_mask, 16'hFFFF);
    check("ex_only_pending", bus.mem_pending, 0);
    cycle();
    check("idle_en", bus.wb_enable_vector_writeback, 0);
    // Load-only writeback
    set_mem(1, 7, 16'h00F0);
    cycle();
    set_mem(0, '0, '0);
    check("mem_only_pending", bus.mem_pending, 1);
    cycle();
    check("mem_only_en", bus.wb_enable_vector_writeback, 1);
    check("mem_only_reg", bus.wb_writeback_reg, 7);
    check("mem_only_drained", bus.mem_pending, 0);
    cycle();
    // Fill under continuous execute traffic
    for (int i = 0; i < 5; i++) begin
      set_ex(1, RW'(20 + i), VL'($urandom));
      set_mem(1, RW'(10 + i), VL'($urandom));
      cycle();
    end
    set_mem(0, '0, '0);
    check("fill_pending", bus.mem_pending, 4);
    check("fill_mem_ready", bus.mem_ready, 0);
    set_ex(0, '0, '0);
    for (int i = 0; i < 6; i++) cycle();
    check("drain_pending", bus.mem_pending, 0);
    // Starvation: one load against a held execute stream
    set_ex(1, 2, 16'h1234);
    set_mem(1, 9, 16'h0000);
    cycle();
    set_mem(0, '0, '0);
    lows = 0;
    for (int i = 0; i < 14; i++) begin
      lows += bus.ex_ready ? 0 : 1;
      set_ex(1, RW'(i), VL'($urandom));
      cycle();
    end
    check("starve_ex_ready_lows", lows, 1);
    check("starve_drained", bus.mem_pending, 0);
    set_ex(0, '0, '0);
    cycle();
    // Ordering with execute idle
    got.delete();
    for (int i = 1; i <= 6; i++) begin
      set_mem(i <= 3, RW'(i), VL'(i));
      cycle();
      if (bus.wb_enable_vector_writeback) got.push_back(bus.wb_writeback_reg);
    end
    check("order_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("order_reg", got[i], i + 1);
    // Asynchronous reset with queued loads and a live strobe
    for (int i = 0; i < 3; i++) begin
      set_ex(1, RW'(30 + i), VL'($urandom));
      set_mem(1, RW'(4 + i), VL'($urandom));
      cycle();
    end
    check("pre_rst_pending", bus.mem_pending, 3);
    check("pre_rst_en", bus.wb_enable_vector_writeback, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_en", bus.wb_enable_vector_writeback, 0);
    check("async_rst_reg", bus.wb_writeback_reg, 0);
    check("async_rst_value", bus.wb_writeback_value, 0);
    check("async_rst_mask", bus.wb_writeback_mask, 0);
    check("async_rst_pending", bus.mem_pending, 0);
    set_ex(0, '0, '0);
    set_mem(0, '0, '0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    // Random traffic with varying pressure on each source
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 120; i++) begin
        set_ex($urandom_range(0, 9) < 3 + 2 * ph, RW'($urandom), VL'($urandom));
        set_mem($urandom_range(0, 9) < 8 - 2 * ph, RW'($urandom), ($urandom_range(0, 7) == 0) ? '0 : VL'($urandom));
        cycle();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_writeback_arbiter.md
VECTOR_WRITEBACK_ARBITER -- requirements
Module: vector_writeback_arbiter

Interface
REQ-001 SHALL have parameter MEM_FIFO_DEPTH, default 4, depth of the load-writeback queue (power of 2, minimum 2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, number of consecutive cycles a queued load may be denied before it takes priority.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ex_valid  input  1  execute pipeline has a vector writeback.
REQ-006 ex_ready  output  1  execute writeback is accepted this cycle.
REQ-007 ex_reg / ex_value / ex_mask  input  `REG_IDX_WIDTH / `VECTOR_BITS / `VECTOR_LANES  execute writeback register index, data and lane mask.
REQ-008 mem_valid  input  1  load unit has a vector writeback.
REQ-009 mem_ready  output  1  load writeback is enqueued this cycle.
REQ-010 mem_reg / mem_value / mem_mask  input  `REG_IDX_WIDTH / `VECTOR_BITS / `VECTOR_LANES  load writeback register index, data and lane mask.
REQ-011 wb_enable_vector_writeback  output  1  registered write strobe to the vector register file.
REQ-012 wb_writeback_reg / wb_writeback_value / wb_writeback_mask  output  `REG_IDX_WIDTH / `VECTOR_BITS / `VECTOR_LANES  registered write port to the register file.
REQ-013 mem_pending  output  $clog2(MEM_FIFO_DEPTH)+1  current load queue occupancy.

Function
REQ-014 Load requests SHALL enter a FIFO of MEM_FIFO_DEPTH entries; mem_ready = (occupancy < MEM_FIFO_DEPTH), combinational from state only, independent of mem_valid.
REQ-015 A load SHALL be enqueued when mem_valid && mem_ready; a full FIFO SHALL hold mem_ready low, with no overwrite and no drop.
REQ-016 The arbiter SHALL have two states: EX_PRIO (reset state) and MEM_PRIO.
REQ-017 In EX_PRIO: ex_ready = 1; the FIFO head is granted only when ex_valid = 0 and the FIFO is non-empty.
REQ-018 In MEM_PRIO: ex_ready = 0 whenever the FIFO is non-empty, and the FIFO head is granted.
REQ-019 Starve counter: increments each cycle the FIFO is non-empty and not granted, saturating at STARVE_LIMIT; clears on any FIFO grant or when the FIFO is empty.
REQ-020 EX_PRIO -> MEM_PRIO when the counter equals STARVE_LIMIT. MEM_PRIO -> EX_PRIO after exactly one FIFO grant, or if the FIFO is empty.
REQ-021 Exactly one grant SHALL occur per cycle at most; the granted request's reg/value/mask SHALL appear on the wb_* outputs one cycle later, with wb_enable_vector_writeback = 1.
REQ-022 wb_enable_vector_writeback SHALL be 0 in any cycle following a cycle with no grant; wb_* data outputs then hold their previous values.
REQ-023 Simultaneous enqueue and dequeue on a full FIFO SHALL NOT occur (mem_ready is already low); on a non-full FIFO, occupancy is unchanged.
REQ-024 Simultaneous enqueue and dequeue on an empty FIFO: the new entry SHALL NOT bypass the queue; it is granted no earlier than the next cycle.
REQ-025 FIFO read/write pointers SHALL wrap modulo MEM_FIFO_DEPTH; occupancy is tracked with an extra bit so full and empty are distinct.
REQ-026 Loads SHALL be written back in enqueue order; the arbiter does not reorder within a source and does not check register hazards between sources.
REQ-027 Mask bits SHALL pass through unmodified; a zero mask is still a valid grant and produces a strobe.

Reset
REQ-028 While reset = 0: state = EX_PRIO, FIFO empty, mem_pending = 0, starve counter = 0, wb_enable_vector_writeback = 0, wb_writeback_reg = 0, wb_writeback_value = 0, wb_writeback_mask = 0.
REQ-029 Reset asserted mid-operation SHALL discard all queued loads and any in-flight output strobe immediately, without waiting for a clock edge.
REQ-030 After reset deasserts, ex_ready = 1 and mem_ready = 1 in the first cycle.

Verification
REQ-031 ex only: ex_valid=1, ex_reg=3, ex_mask=16'hFFFF -> next cycle wb_enable=1, wb_writeback_reg=3, mask 16'hFFFF; mem_pending stays 0.
REQ-032 mem only: mem_valid=1 for 1 cycle, reg=7 -> mem_pending=1 for 1 cycle, then wb strobe with reg 7 one cycle after the grant.
REQ-033 Fill: ex_valid=1 held, 5 mem requests -> 4 accepted, mem_ready=0 on the 5th, mem_pending=4.
REQ-034 Starvation: ex_valid=1 held, 1 queued load -> after 8 denied cycles, state MEM_PRIO, ex_ready=0 for one cycle, load written back, then ex_ready=1.
REQ-035 Async reset with 3 queued loads and an output strobe high -> all outputs 0 and mem_pending=0 before the next clk edge.
REQ-036 Ordering: enqueue regs 1,2,3 while ex idle -> writebacks in order 1,2,3 on consecutive cycles.
